// File: rtl/rbus_source_unit_pkg.sv
// Shared definitions for the R-bus source stage.
//   state_e        : FSM states of rbus_source_unit (IDLE / FETCH / HOLD)
//   sel_*()        : select-code helpers; the special codes sit directly above
//                    the GPR codes, and NRB is the all-ones code of the field.
package rbus_source_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic int sel_ra(input int num_gpr);
        return num_gpr;
    endfunction

    function automatic int sel_rap(input int num_gpr);
        return num_gpr + 1;
    endfunction

    function automatic int sel_slt(input int num_gpr);
        return num_gpr + 2;
    endfunction

    function automatic int sel_llt(input int num_gpr);
        return num_gpr + 3;
    endfunction

    function automatic int sel_nrb(input int sel_width);
        return (1 << sel_width) - 1;
    endfunction

endpackage

// File: rtl/rbus_source_unit_gpr.sv
// General register file for the R-bus source stage.
//   clk, rst_n : clock, asynchronous active-low reset (clears all registers)
//   wr_en      : write strobe, already qualified to GPR codes by the caller
//   wr_idx     : register written at the rising edge
//   wr_data    : data written
//   rd_idx     : register read combinationally
//   rd_data    : read data; a same-cycle write to rd_idx is forwarded
module rbus_gpr_file #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_GPR    = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_GPR];
    logic [DATA_WIDTH-1:0] mem_d [NUM_GPR];

    always_comb begin
        mem_d = mem_q;
        // Guard keeps indices past NUM_GPR harmless when NUM_GPR is not a power of two.
        if (wr_en && (int'(wr_idx) < NUM_GPR)) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_GPR) begin
            rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/rbus_source_unit.sv
// R-bus source stage: decodes the per-microinstruction source select and
// drives a registered R-bus word.
//   clk, rst_n            : clock, asynchronous active-low reset
//   sel_valid/sel         : source request and select code
//   slt_field             : short literal (zero-extended) for SLT
//   busy                  : request will not be accepted this cycle
//   wr_en/wr_sel/wr_data  : W-bus write into a GPR or RA
//   llt_req/llt_ack/llt_data : long-literal fetch handshake
//   rbus_valid/ready/data : R-bus output word
//   llt_timeout           : one-cycle pulse, fetch gave up (word 0 driven)
//   illegal_sel           : one-cycle pulse, reserved code accepted
//
// Handshake: a request is taken at the rising edge where sel_valid=1 and
// busy=0. An output word is transferred at the rising edge where
// rbus_valid=1 and rbus_ready=1; while rbus_valid=1 and rbus_ready=0 the word
// and rbus_valid stay unchanged. rbus_data reads 0 whenever rbus_valid=0.
module rbus_source_unit
    import rbus_source_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_GPR     = 8,
    parameter int SEL_WIDTH   = 4,
    parameter int SLT_WIDTH   = 8,
    parameter int RAP_STEP    = 1,
    parameter int LLT_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_valid,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [SLT_WIDTH-1:0]  slt_field,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [SEL_WIDTH-1:0]  wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  llt_req,
    input  logic                  llt_ack,
    input  logic [DATA_WIDTH-1:0] llt_data,
    output logic                  rbus_valid,
    input  logic                  rbus_ready,
    output logic [DATA_WIDTH-1:0] rbus_data,
    output logic                  llt_timeout,
    output logic                  illegal_sel
);

    localparam int IDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
    localparam int CNT_W = $clog2(LLT_TIMEOUT + 1);

    localparam logic [SEL_WIDTH-1:0] SEL_GPR_END = SEL_WIDTH'(NUM_GPR);
    localparam logic [SEL_WIDTH-1:0] SEL_RA      = SEL_WIDTH'(sel_ra(NUM_GPR));
    localparam logic [SEL_WIDTH-1:0] SEL_RAP     = SEL_WIDTH'(sel_rap(NUM_GPR));
    localparam logic [SEL_WIDTH-1:0] SEL_SLT     = SEL_WIDTH'(sel_slt(NUM_GPR));
    localparam logic [SEL_WIDTH-1:0] SEL_LLT     = SEL_WIDTH'(sel_llt(NUM_GPR));
    localparam logic [SEL_WIDTH-1:0] SEL_NRB     = SEL_WIDTH'(sel_nrb(SEL_WIDTH));

    if (NUM_GPR + 4 > (2 ** SEL_WIDTH) - 1) begin : g_sel_space_check
        $error("rbus_source_unit: NUM_GPR+4 must not exceed 2**SEL_WIDTH-1");
    end
    if (LLT_TIMEOUT < 1) begin : g_timeout_check
        $error("rbus_source_unit: LLT_TIMEOUT must be at least 1");
    end

    state_e                state_q, state_d;
    logic                  rbus_valid_q, rbus_valid_d;
    logic [DATA_WIDTH-1:0] rbus_data_q, rbus_data_d;
    logic [DATA_WIDTH-1:0] ra_q, ra_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  llt_timeout_q, llt_timeout_d;
    logic                  illegal_sel_q, illegal_sel_d;

    logic                  accept;
    logic                  sel_is_gpr;
    logic                  gpr_we;
    logic [DATA_WIDTH-1:0] gpr_rd_data;
    logic [DATA_WIDTH-1:0] ra_fwd;

    assign sel_is_gpr = (sel < SEL_GPR_END);
    assign gpr_we     = wr_en && (wr_sel < SEL_GPR_END);

    // RA value as seen this cycle: a same-cycle W-bus write wins over the stored value.
    assign ra_fwd = (wr_en && (wr_sel == SEL_RA)) ? wr_data : ra_q;

    assign busy   = (state_q != ST_IDLE) || (rbus_valid_q && !rbus_ready);
    assign accept = sel_valid && !busy;

    rbus_gpr_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_GPR    (NUM_GPR),
        .IDX_W      (IDX_W)
    ) u_gpr (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (gpr_we),
        .wr_idx  (IDX_W'(wr_sel)),
        .wr_data (wr_data),
        .rd_idx  (IDX_W'(sel)),
        .rd_data (gpr_rd_data)
    );

    always_comb begin
        state_d       = state_q;
        rbus_valid_d  = rbus_valid_q;
        rbus_data_d   = rbus_data_q;
        ra_d          = ra_fwd;
        cnt_d         = cnt_q;
        llt_timeout_d = 1'b0;
        illegal_sel_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rbus_valid_q) begin
                    if (rbus_ready) begin
                        rbus_valid_d = 1'b0;
                        rbus_data_d  = '0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                // accept already implies the output slot is free this edge.
                if (accept) begin
                    if (sel_is_gpr) begin
                        rbus_valid_d = 1'b1;
                        rbus_data_d  = gpr_rd_data;
                    end else if (sel == SEL_RA) begin
                        rbus_valid_d = 1'b1;
                        rbus_data_d  = ra_fwd;
                    end else if (sel == SEL_RAP) begin
                        rbus_valid_d = 1'b1;
                        rbus_data_d  = ra_fwd;
                        ra_d         = ra_fwd + DATA_WIDTH'(RAP_STEP);
                    end else if (sel == SEL_SLT) begin
                        rbus_valid_d = 1'b1;
                        rbus_data_d  = DATA_WIDTH'(slt_field);
                    end else if (sel == SEL_LLT) begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                    end else if (sel != SEL_NRB) begin
                        illegal_sel_d = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                // cnt_q holds the number of fetch cycles already spent, so the
                // last allowed cycle is the one where cnt_q == LLT_TIMEOUT-1.
                if (llt_ack) begin
                    rbus_valid_d = 1'b1;
                    rbus_data_d  = llt_data;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else if (cnt_q == CNT_W'(LLT_TIMEOUT - 1)) begin
                    rbus_valid_d  = 1'b1;
                    rbus_data_d   = '0;
                    llt_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (rbus_ready) begin
                    rbus_valid_d = 1'b0;
                    rbus_data_d  = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rbus_valid_q  <= 1'b0;
            rbus_data_q   <= '0;
            ra_q          <= '0;
            cnt_q         <= '0;
            llt_timeout_q <= 1'b0;
            illegal_sel_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rbus_valid_q  <= rbus_valid_d;
            rbus_data_q   <= rbus_data_d;
            ra_q          <= ra_d;
            cnt_q         <= cnt_d;
            llt_timeout_q <= llt_timeout_d;
            illegal_sel_q <= illegal_sel_d;
        end
    end

    assign llt_req     = (state_q == ST_FETCH);
    assign rbus_valid  = rbus_valid_q;
    assign rbus_data   = rbus_valid_q ? rbus_data_q : '0;
    assign llt_timeout = llt_timeout_q;
    assign illegal_sel = illegal_sel_q;

endmodule

// File: tb/tb_rbus_source_unit.sv
module tb_rbus_source_unit;

    localparam int W      = 16;
    localparam int LLT_TO = 15;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel_valid;
    logic [3:0]   sel;
    logic [7:0]   slt_field;
    logic         busy;
    logic         wr_en;
    logic [3:0]   wr_sel;
    logic [W-1:0] wr_data;
    logic         llt_req;
    logic         llt_ack;
    logic [W-1:0] llt_data;
    logic         rbus_valid;
    logic         rbus_ready;
    logic [W-1:0] rbus_data;
    logic         llt_timeout;
    logic         illegal_sel;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    rbus_source_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .slt_field   (slt_field),
        .busy        (busy),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .llt_req     (llt_req),
        .llt_ack     (llt_ack),
        .llt_data    (llt_data),
        .rbus_valid  (rbus_valid),
        .rbus_ready  (rbus_ready),
        .rbus_data   (rbus_data),
        .llt_timeout (llt_timeout),
        .illegal_sel (illegal_sel)
    );

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    int           ill_q[$];
    int           tmo_q[$];

    // Reference model: register contents as the specification defines them.
    logic [W-1:0] m_gpr [8];
    logic [W-1:0] m_ra;
    bit           ready_rand = 1'b0;
    bit           ready_fix  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_gpr[i] = '0;
        m_ra = '0;
        exp_q.delete();
        ill_q.delete();
        tmo_q.delete();
    endtask

    // ---------------- monitor ----------------
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(rbus_valid), 32'd1);
                check("hold_data", 32'(rbus_data), 32'(prev_data));
            end
            if (rbus_valid && rbus_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", rbus_data, cyc);
                end else begin
                    check("rbus_data", 32'(rbus_data), 32'(exp_q.pop_front()));
                end
            end
            if (!rbus_valid) check("idle_data_zero", 32'(rbus_data), 32'd0);
            prev_stall = rbus_valid && !rbus_ready;
            prev_data  = rbus_data;

            if (illegal_sel) begin
                if (ill_q.size() > 0 && ill_q[0] == cyc) begin
                    n_vec++;
                    void'(ill_q.pop_front());
                end else check("illegal_sel_spurious", 32'd1, 32'd0);
            end else if (ill_q.size() > 0 && ill_q[0] == cyc) begin
                void'(ill_q.pop_front());
                check("illegal_sel_missing", 32'd0, 32'd1);
            end

            if (llt_timeout) begin
                if (tmo_q.size() > 0 && tmo_q[0] == cyc) begin
                    n_vec++;
                    void'(tmo_q.pop_front());
                end else check("llt_timeout_spurious", 32'd1, 32'd0);
            end else if (tmo_q.size() > 0 && tmo_q[0] == cyc) begin
                void'(tmo_q.pop_front());
                check("llt_timeout_missing", 32'd0, 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock of stimulus; decides acceptance from busy just before the edge
    // and updates the reference model for everything that edge does.
    task automatic do_cycle(input bit v, input logic [3:0] s, input logic [7:0] slt,
                            input bit we, input logic [3:0] ws, input logic [W-1:0] wd,
                            output bit acc);
        logic [W-1:0] ra_f;
        sel_valid  = v;
        sel        = s;
        slt_field  = slt;
        wr_en      = we;
        wr_sel     = ws;
        wr_data    = wd;
        rbus_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fix;
        @(negedge clk);
        acc  = v && !busy;
        ra_f = (we && ws == 4'd8) ? wd : m_ra;
        if (acc) begin
            if (s < 4'd8)                     exp_q.push_back((we && ws == s) ? wd : m_gpr[s[2:0]]);
            else if (s == 4'd8 || s == 4'd9)  exp_q.push_back(ra_f);
            else if (s == 4'd10)              exp_q.push_back({8'h00, slt});
            else if (s >= 4'd12 && s <= 4'd14) ill_q.push_back(cyc + 1);
        end
        if (we && ws < 4'd8) m_gpr[ws[2:0]] = wd;
        m_ra = ra_f;
        if (acc && s == 4'd9) m_ra = ra_f + 16'd1;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic issue(input logic [3:0] s, input logic [7:0] slt, output bit acc);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) do_cycle(1'b1, s, slt, 1'b0, 4'd0, '0, acc);
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: sel %0d not accepted within 40 cycles", s);
        end
    endtask

    // Runs the fetch window after an accepted LLT. ack_at beyond LLT_TO means no ack.
    task automatic llt_phase(input int ack_at, input logic [W-1:0] d);
        bit done = 1'b0;
        for (int k = 1; k <= LLT_TO && !done; k++) begin
            llt_ack    = (k == ack_at);
            llt_data   = (k == ack_at) ? d : W'($urandom);
            rbus_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fix;
            @(negedge clk);
            check("llt_req_high", 32'(llt_req), 32'd1);
            check("busy_fetch", 32'(busy), 32'd1);
            if (k == ack_at) begin
                exp_q.push_back(d);
                done = 1'b1;
            end else if (k == LLT_TO) begin
                exp_q.push_back('0);
                tmo_q.push_back(cyc + 1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            llt_ack = 1'b0;
        end
        @(negedge clk);
        check("llt_req_low", 32'(llt_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        logic [3:0] s;
        sel_valid  = 1'b0;
        sel        = '0;
        slt_field  = '0;
        wr_en      = 1'b0;
        wr_sel     = '0;
        wr_data    = '0;
        llt_ack    = 1'b0;
        llt_data   = '0;
        rbus_ready = 1'b1;
        rst_n      = 1'b0;
        model_reset();

        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rbus_valid", 32'(rbus_valid), 32'd0);
        check("reset_rbus_data", 32'(rbus_data), 32'd0);
        check("reset_llt_req", 32'(llt_req), 32'd0);
        check("reset_llt_timeout", 32'(llt_timeout), 32'd0);
        check("reset_illegal_sel", 32'(illegal_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // GPR write, read, and same-cycle forwarding
        do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 16'h1234, acc);
        issue(4'd3, 8'h00, acc);
        do_cycle(1'b1, 4'd3, 8'h00, 1'b1, 4'd3, 16'h5678, acc);
        check("fwd_accept", 32'(acc), 32'd1);

        // RA post-increment wrap, RA write colliding with RAP
        do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd8, 16'hFFFF, acc);
        issue(4'd9, 8'h00, acc);
        issue(4'd9, 8'h00, acc);
        issue(4'd8, 8'h00, acc);
        do_cycle(1'b1, 4'd9, 8'h00, 1'b1, 4'd8, 16'h0100, acc);
        issue(4'd8, 8'h00, acc);

        // Long literal: ack on 3rd cycle, no ack, ack exactly at the limit
        issue(4'd11, 8'h00, acc);
        if (acc) llt_phase(3, 16'hBEEF);
        issue(4'd11, 8'h00, acc);
        if (acc) llt_phase(LLT_TO + 1, 16'h0000);
        issue(4'd11, 8'h00, acc);
        if (acc) llt_phase(LLT_TO, 16'h1357);

        // Back-pressure: SLT word held for 4 stalled cycles
        ready_fix = 1'b0;
        issue(4'd10, 8'hA5, acc);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 4'd10, 8'h5A, 1'b0, 4'd0, '0, acc);
            check("stall_no_accept", 32'(acc), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_data", 32'(rbus_data), 32'h00A5);
        end
        ready_fix = 1'b1;
        issue(4'd10, 8'h5A, acc);

        // NRB drives nothing; reserved codes pulse illegal_sel
        issue(4'd15, 8'h00, acc);
        issue(4'd12, 8'h00, acc);
        issue(4'd13, 8'h00, acc);
        issue(4'd14, 8'h00, acc);
        issue(4'd15, 8'h00, acc);
        repeat (3) do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, '0, acc);

        // Randomized traffic with random back-pressure and writes
        ready_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 19);
            s = (r < 16) ? 4'(r) : 4'(r - 16);
            do_cycle($urandom_range(0, 3) != 0, s, 8'($urandom), $urandom_range(0, 1) == 1,
                     4'($urandom_range(0, 15)), W'($urandom), acc);
            if (acc && s == 4'd11) llt_phase($urandom_range(1, LLT_TO + 2), W'($urandom));
        end
        ready_rand = 1'b0;
        ready_fix  = 1'b1;
        repeat (3) do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, '0, acc);
        check("random_drain", 32'(exp_q.size()), 32'd0);

        // Reset during a fetch drops everything
        do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 16'h4321, acc);
        do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd8, 16'h0042, acc);
        issue(4'd11, 8'h00, acc);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midfetch_llt_req", 32'(llt_req), 32'd0);
        check("midfetch_busy", 32'(busy), 32'd0);
        check("midfetch_rbus_valid", 32'(rbus_valid), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(4'd3, 8'h00, acc);
        issue(4'd8, 8'h00, acc);
        repeat (3) do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, '0, acc);

        check("final_word_queue", 32'(exp_q.size()), 32'd0);
        check("final_illegal_queue", 32'(ill_q.size()), 32'd0);
        check("final_timeout_queue", 32'(tmo_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d cycles elapsed", cyc);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
